// File: rtl/cursor_input_arbiter.sv
// Per-frame arbiter between mouse displacement and keyboard keys for the cursor motion datapath.
// Picks one owner per frame and emits a registered, saturated signed step per axis.
module cursor_input_arbiter #(
    parameter int unsigned DEADZONE     = 3,
    parameter int unsigned SHIFT        = 1,
    parameter int unsigned MAX_STEP     = 8,
    parameter int unsigned HOLD_FRAMES  = 15,
    parameter int unsigned ACCEL_FRAMES = 8,
    parameter logic [7:0]  KEY_LEFT     = 8'h04,
    parameter logic [7:0]  KEY_RIGHT    = 8'h07,
    parameter logic [7:0]  KEY_UP       = 8'h1A,
    parameter logic [7:0]  KEY_DOWN     = 8'h16
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] x_disp,
    input  logic [7:0] y_disp,
    input  logic       disp_valid,
    output logic [9:0] motion_x,
    output logic [9:0] motion_y,
    output logic       motion_valid,
    output logic [1:0] owner
);

    localparam int unsigned StepW  = $clog2(MAX_STEP + 1);
    localparam int unsigned AccelW = $clog2(ACCEL_FRAMES + 1);
    localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StMouse = 2'b01,
        StKey   = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [HoldW-1:0]    hold_q, hold_d, hold_inc;
    logic [AccelW-1:0]   accel_cnt_q, accel_cnt_d, cnt_inc;
    logic [StepW-1:0]    key_step_q, key_step_d, step_now;
    logic [StepW:0]      step_grow;
    logic [7:0]          key_prev_q, key_prev_d;
    logic [9:0]          motion_x_q, motion_x_d;
    logic [9:0]          motion_y_q, motion_y_d;
    logic                motion_valid_q, motion_valid_d;

    logic [9:0]          mouse_x, mouse_y;
    logic                mouse_act;
    logic                key_req, same_key;
    logic [9:0]          key_step10, key_x, key_y;

    // Magnitude is taken in 9 bits so -128 survives; shifting the magnitude rounds toward zero.
    function automatic logic [9:0] mouse_axis(input logic [7:0] d, input logic valid);
        logic [8:0] ext;
        logic [8:0] mag;
        logic [8:0] shifted;
        logic [8:0] sat;
        ext     = {d[7], d};
        mag     = ext[8] ? (~ext + 9'd1) : ext;
        shifted = mag >> SHIFT;
        sat     = (shifted > 9'(MAX_STEP)) ? 9'(MAX_STEP) : shifted;
        if (!valid || (mag < 9'(DEADZONE))) begin
            return 10'd0;
        end
        return ext[8] ? (~{1'b0, sat} + 10'd1) : {1'b0, sat};
    endfunction

    always_comb begin
        mouse_x   = mouse_axis(x_disp, disp_valid);
        mouse_y   = mouse_axis(y_disp, disp_valid);
        mouse_act = (mouse_x != 10'd0) || (mouse_y != 10'd0);
    end

    always_comb begin
        key_req = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT) ||
                  (keycode == KEY_UP)   || (keycode == KEY_DOWN);
        same_key = key_req && (keycode == key_prev_q);
        step_now = same_key ? key_step_q : StepW'(1);
        cnt_inc  = (same_key ? accel_cnt_q : AccelW'(0)) + AccelW'(1);
        step_grow = {1'b0, step_now} + (StepW + 1)'(1);
        key_prev_d = keycode;

        if (!key_req) begin
            accel_cnt_d = '0;
            key_step_d  = StepW'(1);
        end else if (cnt_inc == AccelW'(ACCEL_FRAMES)) begin
            accel_cnt_d = '0;
            key_step_d  = (step_grow > (StepW + 1)'(MAX_STEP)) ? StepW'(MAX_STEP)
                                                               : step_grow[StepW-1:0];
        end else begin
            accel_cnt_d = cnt_inc;
            key_step_d  = step_now;
        end

        key_step10 = 10'(step_now);
        key_x = 10'd0;
        key_y = 10'd0;
        if (keycode == KEY_LEFT) begin
            key_x = ~key_step10 + 10'd1;
        end else if (keycode == KEY_RIGHT) begin
            key_x = key_step10;
        end else if (keycode == KEY_UP) begin
            key_y = ~key_step10 + 10'd1;
        end else if (keycode == KEY_DOWN) begin
            key_y = key_step10;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        motion_x_d = 10'd0;
        motion_y_d = 10'd0;
        hold_inc   = (hold_q == HoldW'(HOLD_FRAMES)) ? hold_q : hold_q + HoldW'(1);

        case (state_q)
            StIdle: begin
                hold_d = '0;
                if (mouse_act) begin
                    state_d    = StMouse;
                    motion_x_d = mouse_x;
                    motion_y_d = mouse_y;
                end else if (key_req) begin
                    state_d    = StKey;
                    motion_x_d = key_x;
                    motion_y_d = key_y;
                end
            end
            StMouse: begin
                // Release frame outputs 0 even if a requester is active; it is granted next frame.
                if (hold_q >= HoldW'(HOLD_FRAMES)) begin
                    state_d = StIdle;
                    hold_d  = '0;
                end else begin
                    motion_x_d = mouse_x;
                    motion_y_d = mouse_y;
                    hold_d     = mouse_act ? '0 : hold_inc;
                end
            end
            StKey: begin
                if (hold_q >= HoldW'(HOLD_FRAMES)) begin
                    state_d = StIdle;
                    hold_d  = '0;
                end else begin
                    if (key_req) begin
                        motion_x_d = key_x;
                        motion_y_d = key_y;
                    end
                    hold_d = key_req ? '0 : hold_inc;
                end
            end
            default: begin
                state_d = StIdle;
                hold_d  = '0;
            end
        endcase

        motion_valid_d = (motion_x_d != 10'd0) || (motion_y_d != 10'd0);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= StIdle;
            hold_q         <= '0;
            accel_cnt_q    <= '0;
            key_step_q     <= StepW'(1);
            key_prev_q     <= 8'h00;
            motion_x_q     <= 10'd0;
            motion_y_q     <= 10'd0;
            motion_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            accel_cnt_q    <= accel_cnt_d;
            key_step_q     <= key_step_d;
            key_prev_q     <= key_prev_d;
            motion_x_q     <= motion_x_d;
            motion_y_q     <= motion_y_d;
            motion_valid_q <= motion_valid_d;
        end
    end

    assign motion_x     = motion_x_q;
    assign motion_y     = motion_y_q;
    assign motion_valid = motion_valid_q;
    assign owner        = state_q;

endmodule

// File: tb/tb_cursor_input_arbiter.sv
// Self-checking bench for cursor_input_arbiter: a vector table plus hand-written multi-frame
// sequences, with expected outputs queued at drive time and popped after each edge.
module tb_cursor_input_arbiter;

    localparam logic [7:0] KL = 8'h04;
    localparam logic [7:0] KR = 8'h07;
    localparam logic [7:0] KU = 8'h1A;
    localparam logic [7:0] KD = 8'h16;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic [7:0] x_disp = 8'h00;
    logic [7:0] y_disp = 8'h00;
    logic       disp_valid = 1'b0;
    logic [9:0] motion_x, motion_y;
    logic       motion_valid;
    logic [1:0] owner;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]        kc;
        logic [7:0]        x;
        logic [7:0]        y;
        logic              v;
        logic signed [9:0] ex;
        logic signed [9:0] ey;
        logic [1:0]        eo;
    } vec_t;

    typedef struct {
        logic signed [9:0] ex;
        logic signed [9:0] ey;
        logic [1:0]        eo;
        logic              chk_m;
        string             name;
    } exp_t;

    vec_t tbl [12];
    exp_t sb [$];

    cursor_input_arbiter dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .x_disp       (x_disp),
        .y_disp       (y_disp),
        .disp_valid   (disp_valid),
        .motion_x     (motion_x),
        .motion_y     (motion_y),
        .motion_valid (motion_valid),
        .owner        (owner)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic compare_head();
        exp_t e;
        logic ev;
        logic bad;
        e  = sb.pop_front();
        ev = (e.ex != 0) || (e.ey != 0);
        bad = (owner !== e.eo);
        if (e.chk_m) begin
            bad = bad || (motion_x !== e.ex) || (motion_y !== e.ey) || (motion_valid !== ev);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d v=%b own=%b, want x=%0d y=%0d v=%b own=%b",
                     e.name, $signed(motion_x), $signed(motion_y), motion_valid, owner,
                     e.ex, e.ey, ev, e.eo);
        end
    endtask

    task automatic frame(input logic [7:0] kc, input logic [7:0] x, input logic [7:0] y,
                         input logic v, input logic signed [9:0] ex, input logic signed [9:0] ey,
                         input logic [1:0] eo, input logic chk_m, input string name);
        exp_t e;
        @(negedge frame_clk);
        keycode = kc; x_disp = x; y_disp = y; disp_valid = v;
        e.ex = ex; e.ey = ey; e.eo = eo; e.chk_m = chk_m; e.name = name;
        sb.push_back(e);
        @(posedge frame_clk);
        #1;
        compare_head();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (motion_x !== 10'd0 || motion_y !== 10'd0 || motion_valid !== 1'b0 ||
            owner !== 2'b00) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d v=%b own=%b, want all zero", name,
                     $signed(motion_x), $signed(motion_y), motion_valid, owner);
        end
    endtask

    task automatic do_reset();
        @(negedge frame_clk);
        keycode = 8'h00; x_disp = 8'h00; y_disp = 8'h00; disp_valid = 1'b0;
        Reset = 1'b1;
        #1;
        check_zero("reset_state");
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 1'b0,  10'sd0,  10'sd0, 2'b00};
        tbl[1]  = '{8'h00, 8'h02, 8'hFA, 1'b1,  10'sd0, -10'sd3, 2'b01};
        tbl[2]  = '{8'h00, 8'h80, 8'h00, 1'b1, -10'sd8,  10'sd0, 2'b01};
        tbl[3]  = '{8'h00, 8'h7F, 8'h00, 1'b1,  10'sd8,  10'sd0, 2'b01};
        tbl[4]  = '{8'h00, 8'hFD, 8'h00, 1'b1, -10'sd1,  10'sd0, 2'b01};
        tbl[5]  = '{8'h00, 8'h03, 8'h05, 1'b1,  10'sd1,  10'sd2, 2'b01};
        tbl[6]  = '{8'h00, 8'hFE, 8'h02, 1'b1,  10'sd0,  10'sd0, 2'b01};
        tbl[7]  = '{8'h00, 8'h40, 8'h40, 1'b0,  10'sd0,  10'sd0, 2'b01};
        tbl[8]  = '{KL,    8'h00, 8'h00, 1'b0,  10'sd0,  10'sd0, 2'b01};
        tbl[9]  = '{8'h00, 8'h0C, 8'hF4, 1'b1,  10'sd6, -10'sd6, 2'b01};
        tbl[10] = '{8'h00, 8'h11, 8'hEF, 1'b1,  10'sd8, -10'sd8, 2'b01};
        tbl[11] = '{8'h00, 8'h81, 8'h03, 1'b1, -10'sd8,  10'sd1, 2'b01};

        repeat (2) @(posedge frame_clk);
        #1;
        check_zero("initial_reset");
        @(negedge frame_clk);
        Reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            frame(tbl[i].kc, tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].ex, tbl[i].ey, tbl[i].eo,
                  1'b1, $sformatf("vec%0d", i));
        end

        // Same-frame tie: mouse wins, key held through the mouse hold-off.
        do_reset();
        frame(KU, 8'h10, 8'h00, 1'b1, 10'sd8, 10'sd0, 2'b01, 1'b1, "tie_grant");
        for (int i = 0; i < 15; i++) begin
            frame(KU, 8'h00, 8'h00, 1'b0, 10'sd0, 10'sd0, 2'b01, 1'b1,
                  $sformatf("tie_hold%0d", i));
        end
        frame(KU, 8'h00, 8'h00, 1'b0, 10'sd0, 10'sd0, 2'b00, 1'b1, "tie_release");
        frame(KU, 8'h00, 8'h00, 1'b0, 10'sd0, 10'sd0, 2'b10, 1'b0, "tie_key_grant");

        // Key acceleration ramp from IDLE.
        do_reset();
        for (int f = 0; f < 34; f++) begin
            int s;
            s = 1 + f / 8;
            if (s > 8) s = 8;
            frame(KR, 8'h00, 8'h00, 1'b0, 10'(s), 10'sd0, 2'b10, 1'b1,
                  $sformatf("ramp%0d", f));
        end

        // Asynchronous reset mid-KEY with step 5, key still held.
        #2;
        Reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge frame_clk);
        Reset = 1'b0;
        begin
            exp_t e;
            e.ex = 10'sd1; e.ey = 10'sd0; e.eo = 2'b10; e.chk_m = 1'b1; e.name = "post_reset";
            sb.push_back(e);
            @(posedge frame_clk);
            #1;
            compare_head();
        end
        frame(KD, 8'h00, 8'h00, 1'b0, 10'sd0, 10'sd1, 2'b10, 1'b1, "key_down");
        frame(KU, 8'h00, 8'h00, 1'b0, 10'sd0, -10'sd1, 2'b10, 1'b1, "key_up");
        frame(KL, 8'h00, 8'h00, 1'b0, -10'sd1, 10'sd0, 2'b10, 1'b1, "key_left");
        frame(8'h05, 8'h10, 8'h00, 1'b1, 10'sd0, 10'sd0, 2'b10, 1'b1, "key_mouse_ignored");
        for (int i = 0; i < 14; i++) begin
            frame(8'h00, 8'h00, 8'h00, 1'b0, 10'sd0, 10'sd0, 2'b10, 1'b1,
                  $sformatf("key_hold%0d", i));
        end
        frame(8'h00, 8'h10, 8'h00, 1'b1, 10'sd0, 10'sd0, 2'b00, 1'b1, "key_release");
        frame(8'h00, 8'h10, 8'h00, 1'b1, 10'sd8, 10'sd0, 2'b01, 1'b1, "mouse_after_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
